// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Holds a shadow/display register pair so new values only switch in at frame boundaries.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 27000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   value_i,
  input  logic                      load_i,
  input  logic                      lz_blank_i,
  output logic [3:0]                digit_o,
  output logic                      blank_o,
  output logic [NUM_DIGITS-1:0]     an_o,
  output logic                      frame_done_o,
  output logic                      load_pending_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Scan and load state
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [VAL_W-1:0]      r_shd;
  logic [VAL_W-1:0]      r_disp;
  logic                  r_pending;

  // Registered outputs
  logic [3:0]            r_digit;
  logic                  r_blank;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_done;
  logic                  r_load_pending;

  logic                  w_cnt_wrap;
  logic                  w_fb;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [VAL_W-1:0]      w_shd_nxt;
  logic [VAL_W-1:0]      w_disp_nxt;
  logic                  w_pending_nxt;

  logic [NUM_DIGITS-1:0] w_zero_from;
  logic [NUM_DIGITS-1:0] w_an_drive;
  logic [3:0]            w_digit_nxt;
  logic                  w_zero_sel;
  logic                  w_in_blank;
  logic                  w_suppress;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic                  w_blank_nxt;
  logic                  w_frame_done_nxt;

  // Slot counter and digit index
  always_comb begin
    w_cnt_wrap = (r_cnt == CNT_LAST);
    w_fb       = w_cnt_wrap && (r_idx == IDX_LAST);
    w_cnt_nxt  = w_cnt_wrap ? '0 : r_cnt + 1'b1;
    w_idx_nxt  = r_idx;
    if (w_cnt_wrap) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Load handshake: load_i is a one-cycle strobe with no acknowledge; the
  // last strobe before a frame boundary wins, and a strobe landing on the
  // boundary cycle itself bypasses the shadow and never raises pending.
  always_comb begin
    w_shd_nxt     = load_i ? value_i : r_shd;
    w_disp_nxt    = r_disp;
    w_pending_nxt = r_pending;
    if (w_fb) begin
      w_pending_nxt = 1'b0;
      if (load_i) begin
        w_disp_nxt = value_i;
      end else if (r_pending) begin
        w_disp_nxt = r_shd;
      end
    end else if (load_i) begin
      w_pending_nxt = 1'b1;
    end
  end

  // w_zero_from[k] is set when nibbles k..NUM_DIGITS-1 are all zero
  always_comb begin
    logic acc;
    acc = 1'b1;
    w_zero_from = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc = acc && (w_disp_nxt[4*k +: 4] == 4'd0);
      w_zero_from[k] = acc;
    end
  end

  // Output path evaluated against next-state cnt/idx so registers line up
  always_comb begin
    w_digit_nxt = 4'd0;
    w_an_drive  = '1;
    w_zero_sel  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_idx_nxt == IDX_W'(k)) begin
        w_digit_nxt   = w_disp_nxt[4*k +: 4];
        w_an_drive[k] = 1'b0;
        w_zero_sel    = w_zero_from[k];
      end
    end
    w_in_blank       = (w_cnt_nxt < CNT_BLANK);
    w_suppress       = lz_blank_i && (w_idx_nxt != '0) && w_zero_sel;
    w_lit            = !w_in_blank && !w_suppress;
    w_an_nxt         = w_lit ? w_an_drive : '1;
    w_blank_nxt      = !w_lit;
    w_frame_done_nxt = (w_cnt_nxt == CNT_LAST) && (w_idx_nxt == IDX_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shd     <= '0;
      r_disp    <= '0;
      r_pending <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shd     <= w_shd_nxt;
      r_disp    <= w_disp_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit        <= 4'd0;
      r_blank        <= 1'b1;
      r_an           <= '1;
      r_frame_done   <= 1'b0;
      r_load_pending <= 1'b0;
    end else begin
      r_digit        <= w_digit_nxt;
      r_blank        <= w_blank_nxt;
      r_an           <= w_an_nxt;
      r_frame_done   <= w_frame_done_nxt;
      r_load_pending <= w_pending_nxt;
    end
  end

  assign digit_o        = r_digit;
  assign blank_o        = r_blank;
  assign an_o           = r_an;
  assign frame_done_o   = r_frame_done;
  assign load_pending_o = r_load_pending;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
// Each frame is checked cycle by cycle against hand-written digit and lit-slot tables.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] value_i;
  logic        load_i;
  logic        lz_blank_i;
  logic [3:0]  digit_o;
  logic        blank_o;
  logic [3:0]  an_o;
  logic        frame_done_o;
  logic        load_pending_o;

  int n_cmp;
  int n_err;
  int frame_no;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .value_i       (value_i),
    .load_i        (load_i),
    .lz_blank_i    (lz_blank_i),
    .digit_o       (digit_o),
    .blank_o       (blank_o),
    .an_o          (an_o),
    .frame_done_o  (frame_done_o),
    .load_pending_o(load_pending_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " an"},      32'(an_o),           32'hF);
    chk({tag, " blank"},   32'(blank_o),        32'd1);
    chk({tag, " digit"},   32'(digit_o),        32'd0);
    chk({tag, " fdone"},   32'(frame_done_o),   32'd0);
    chk({tag, " pending"}, 32'(load_pending_o), 32'd0);
  endtask

  // Runs ncyc cycles of a frame starting at slot 0 / cnt 0. dig holds the
  // displayed nibbles (slot k = dig[4k+3:4k]); lit marks slots whose drive
  // phase lights the anode. la/lb are frame positions for loads (-1 = none).
  task automatic run_frame(input logic [15:0] dig, input logic [3:0] lit, input logic lz,
                           input int ncyc, input int la, input logic [15:0] va,
                           input int lb, input logic [15:0] vb);
    logic       pend;
    logic [3:0] exp_an;
    logic       exp_blank;
    logic [3:0] exp_digit;
    string      tag;
    pend = 1'b0;
    lz_blank_i = lz;
    for (int p = 0; p < ncyc; p++) begin
      int k;
      int c;
      k = p / 8;
      c = p % 8;
      exp_digit = dig[4*k +: 4];
      if (c >= 2 && lit[k]) begin
        exp_an    = ~(4'b0001 << k);
        exp_blank = 1'b0;
      end else begin
        exp_an    = 4'b1111;
        exp_blank = 1'b1;
      end
      tag = $sformatf("f%0d p%0d", frame_no, p);
      chk({tag, " digit"},   32'(digit_o),        32'(exp_digit));
      chk({tag, " an"},      32'(an_o),           32'(exp_an));
      chk({tag, " blank"},   32'(blank_o),        32'(exp_blank));
      chk({tag, " fdone"},   32'(frame_done_o),   32'(p == 31));
      chk({tag, " pending"}, 32'(load_pending_o), 32'(pend));
      if (p == la) begin
        load_i  = 1'b1;
        value_i = va;
      end else if (p == lb) begin
        load_i  = 1'b1;
        value_i = vb;
      end
      if (p == 31) pend = 1'b0;
      else if (p == la || p == lb) pend = 1'b1;
      tick();
      load_i  = 1'b0;
      value_i = 16'h0;
    end
    frame_no++;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    frame_no   = 0;
    rst_n      = 1'b0;
    value_i    = 16'h0;
    load_i     = 1'b0;
    lz_blank_i = 1'b0;

    // Power-on reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reset_outputs($sformatf("rst%0d", i));
    end
    rst_n = 1'b1;

    // Frame 0: zeros, all lit; load 1234 at cycle 5, first frame_done at 31
    run_frame(16'h0000, 4'b1111, 1'b0, 32, 5, 16'h1234, -1, 16'h0);
    // Frame 1: 1234 shown as 4,3,2,1; queue 0050
    run_frame(16'h1234, 4'b1111, 1'b0, 32, 10, 16'h0050, -1, 16'h0);
    // Frame 2: 0050 with suppression, slots 2 and 3 dark
    run_frame(16'h0050, 4'b0011, 1'b1, 32, -1, 16'h0, -1, 16'h0);
    // Frame 3: 0050 without suppression; queue 0000
    run_frame(16'h0050, 4'b1111, 1'b0, 32, 3, 16'h0000, -1, 16'h0);
    // Frame 4: 0000 suppressed to a single lit 0; queue 8000
    run_frame(16'h0000, 4'b0001, 1'b1, 32, 20, 16'h8000, -1, 16'h0);
    // Frame 5: 8000 lights every slot; ABCD loaded in the boundary cycle
    run_frame(16'h8000, 4'b1111, 1'b1, 32, 31, 16'hABCD, -1, 16'h0);
    // Frame 6: ABCD; two loads before the boundary, the second wins
    run_frame(16'hABCD, 4'b1111, 1'b1, 32, 4, 16'h1111, 9, 16'h2222);
    // Frame 7: 2222 with 5678 pending, interrupted mid-drive of slot 2
    run_frame(16'h2222, 4'b1111, 1'b1, 20, 10, 16'h5678, -1, 16'h0);

    chk("mid an",      32'(an_o),           32'hB);
    chk("mid digit",   32'(digit_o),        32'h2);
    chk("mid pending", 32'(load_pending_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    tick();
    chk_reset_outputs("rst_hold0");
    tick();
    chk_reset_outputs("rst_hold1");
    rst_n = 1'b1;

    // After reset: display cleared, the pending 5678 discarded
    run_frame(16'h0000, 4'b1111, 1'b0, 32, -1, 16'h0, -1, 16'h0);
    run_frame(16'h0000, 4'b1111, 1'b0, 32, -1, 16'h0, -1, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It holds a packed multi-digit BCD/hex value and presents one 4-bit digit at a time on `digit_o`, which feeds the `bin_to_7seg` decoder. It drives the matching active-low anode line, with a blanking gap between digits to prevent ghosting. New values take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned (2..8).
- `REFRESH_DIV`, 27000: clock cycles per digit slot.
- `BLANK_CYCLES`, 64: cycles at the start of each slot with all anodes off. Must satisfy 1 ≤ BLANK_CYCLES < REFRESH_DIV.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `value_i`  in  4*NUM_DIGITS  packed digits; digit k is `value_i[4k+3:4k]`; digit 0 is rightmost.
- `load_i`  in  1  one-cycle strobe; captures `value_i`.
- `lz_blank_i`  in  1  enables leading-zero suppression.
- `digit_o`  out  4  nibble of the current digit; goes to the decoder `bin_in`.
- `blank_o`  out  1  1 means segments must be forced off (decoder output ignored).
- `an_o`  out  NUM_DIGITS  active-low anode enables.
- `frame_done_o`  out  1  high during the last cycle of each full scan.
- `load_pending_o`  out  1  a captured value is waiting for the frame boundary.

## Operation
- Registers:
  - slot counter `cnt`: 0..REFRESH_DIV-1, wraps to 0.
  - digit index `idx`: 0..NUM_DIGITS-1; increments when `cnt` wraps, and wraps from NUM_DIGITS-1 to 0.
  - shadow register `shd` and display register `disp`, each 4*NUM_DIGITS wide.
  - `pending` flag.
- Load handshake:
  - `load_i` writes `value_i` into `shd` and sets `pending`.
  - Back-to-back loads: the last one wins. No acknowledge exists; `load_pending_o` = `pending`.
- Frame boundary (FB): the cycle where `cnt`==REFRESH_DIV-1 and `idx`==NUM_DIGITS-1. On the edge ending FB:
  - if `load_i` is also high that cycle, `disp` takes `value_i` directly and `pending` stays/clears to 0;
  - else if `pending`, `disp` takes `shd` and `pending` clears;
  - otherwise `disp` is held.
- Slot phases, for the current `idx`:
  - Blank phase (`cnt` < BLANK_CYCLES): `an_o` all 1s, `blank_o`=1.
  - Drive phase: `an_o` = all 1s except bit `idx` = 0, `blank_o`=0. Exception: the digit is suppressed, in which case anodes stay all 1s and `blank_o`=1.
- `digit_o` = `disp` nibble `idx` in both phases.
- Leading-zero suppression (only when `lz_blank_i`=1): digit k>0 is suppressed iff nibbles k..NUM_DIGITS-1 of `disp` are all zero. Digit 0 is never suppressed.
- `lz_blank_i` is sampled combinationally into the registered output path. A change takes effect on the next slot-phase evaluation, with no frame alignment.
- No arithmetic beyond the counters. `cnt` width is clog2(REFRESH_DIV); `idx` width is clog2(NUM_DIGITS), minimum 1.

## Timing
- All outputs are registered. Within any cycle, outputs correspond to the `cnt`/`idx` values held in that same cycle: the output registers are computed from the next-state values.
- Reset values (asserted asynchronously, held while `rst_n`=0):
  - `cnt`=0, `idx`=0, `shd`=0, `disp`=0, `pending`=0.
  - `an_o`=all 1s, `blank_o`=1, `digit_o`=0, `frame_done_o`=0, `load_pending_o`=0.
- First edge after `rst_n` rises: `cnt`=1.
- Slot 0 drive phase begins when `cnt`==BLANK_CYCLES.
- Frame length is NUM_DIGITS*REFRESH_DIV cycles. `frame_done_o` is a single-cycle pulse per frame.
- Load-to-display latency: from the `load_i` edge to the next FB edge. Maximum one frame.
- Reset mid-operation: all state clears immediately, the pending load is discarded, and the display shows zeros after reset.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 (frame = 32 cycles).
1. Hold `rst_n`=0 for 3 cycles, then release → during reset `an_o`=4'b1111, `blank_o`=1, `digit_o`=0, `frame_done_o`=0. First pulse of `frame_done_o` lands at cycle 31 after release.
2. `load_i` with 16'h1234 at cycle 5 → `load_pending_o`=1 from cycle 6 through FB. In the next frame, slot k drive phase shows `digit_o`=4,3,2,1 with `an_o`=1110,1101,1011,0111. Blank cycles 0..1 of each slot show `an_o`=1111.
3. `disp`=16'h0050 with `lz_blank_i`=1 → slots 2 and 3 keep `an_o`=1111 and `blank_o`=1. Slot 1 shows 5, slot 0 shows 0. With `lz_blank_i`=0 all four digits light.
4. `disp`=16'h0000 with `lz_blank_i`=1 → only slot 0 lights with `digit_o`=0. `disp`=16'h8000 → all digits light.
5. `load_i` with 16'hABCD exactly in the FB cycle → next frame shows D,C,B,A and `load_pending_o` never rises. Loads of 16'h1111 then 16'h2222 before FB → 2222 is displayed.
6. Assert `rst_n`=0 mid-drive of slot 2 with a load pending → outputs take reset values asynchronously in that cycle. After release the display shows 0000 and `load_pending_o`=0.
